// File: rtl/bcd2bin_if.sv
// bcd2bin_if: request/response bundle for the BCD-to-binary converter.
//   in_valid/in_ready/bcd       : request handshake, packed BCD digits (bcd[3:0] = units)
//   out_valid/out_ready/bin/err : result handshake, binary value and invalid-digit flag
// Modports: master = producer/consumer side, slave = converter side.
interface bcd2bin_if #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned OUT_WIDTH = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*DIGITS-1:0]    bcd;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   bin;
  logic                   err;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, bin, err
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, bin, err
  );
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bcd2bin_if.slave -- request (in_valid/in_ready/bcd) and
//            result (out_valid/out_ready/bin/err) handshakes
// Optional macro BCD2BIN_DIGIT_CHECK_EN: flag input digits > 9 via err (bin forced to 0).
// Without it err is tied to 0.
module bcd2bin #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned OUT_WIDTH = 10
) (
  input logic      clk,
  input logic      rst_n,
  bcd2bin_if.slave bus
);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + OUT_WIDTH;
  localparam int unsigned CntW = $clog2(OUT_WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(OUT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e               state_q;
  logic [SrW-1:0]       sr_q;
  logic [SrW-1:0]       sr_step;
  logic [CntW-1:0]      cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] bin_q;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q;
  logic dig_err_q;
  logic bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd[4*k +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end
`endif

  // One reverse double-dabble step: shift right, then pull every digit that landed
  // at >= 8 back by 3 (each digit on its own, no borrow between digits).
  always_comb begin
    sr_step = sr_q >> 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_step[OUT_WIDTH + 4*k + 3]) begin
        sr_step[OUT_WIDTH + 4*k +: 4] = sr_step[OUT_WIDTH + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q       <= 1'b0;
      dig_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            sr_q       <= {bus.bcd, {OUT_WIDTH{1'b0}}};
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StConv;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            dig_err_q  <= bcd_bad;
`endif
          end
        end
        StConv: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q       <= dig_err_q;
            bin_q       <= dig_err_q ? '0 : sr_step[OUT_WIDTH-1:0];
`else
            bin_q       <= sr_step[OUT_WIDTH-1:0];
`endif
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bin       = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
